// File: rtl/conv3x3_window_pkg.sv
// Shared CNN stage parameters and the saturate helper reused by the other stages.
package conv3x3_window_pkg;
  localparam int CNN_DATA_WIDTH = 8;
  localparam int CNN_IMG_WIDTH  = 28;
  localparam int CNN_ACC_WIDTH  = 2*CNN_DATA_WIDTH + 4;
  localparam int CNN_SHIFT      = 4;
  localparam int NUM_TAPS       = 9;
  localparam int COL_W          = 16;

  typedef logic [COL_W-1:0] col_t;

  // Clamp a signed value into the range of a dw-bit signed number.
  function automatic longint sat_clip(input longint v, input int dw);
    longint hi, lo, r;
    hi = (longint'(1) <<< (dw - 1)) - longint'(1);
    lo = -(longint'(1) <<< (dw - 1));
    r  = v;
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    return r;
  endfunction
endpackage

// File: rtl/conv3x3_window_if.sv
// Column-in / pixel-out stream plus kernel write port of the 3x3 conv stage.
interface conv3x3_window_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] row0_px;
  logic signed [DATA_WIDTH-1:0] row1_px;
  logic signed [DATA_WIDTH-1:0] row2_px;
  logic                         w_we;
  logic [3:0]                   w_addr;
  logic signed [DATA_WIDTH-1:0] w_data;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] pix_out;
  logic [15:0]                  out_col;

  modport master (
    output in_valid, row0_px, row1_px, row2_px, w_we, w_addr, w_data,
    input  out_valid, pix_out, out_col
  );
  modport slave (
    input  in_valid, row0_px, row1_px, row2_px, w_we, w_addr, w_data,
    output out_valid, pix_out, out_col
  );
endinterface

// File: rtl/conv3x3_window_sat_shift.sv
// Combinational post-scale: arithmetic shift, optional ReLU, saturate to pixel width.
module sat_shift
  import conv3x3_window_pkg::*;
#(
  parameter int ACC_WIDTH  = CNN_ACC_WIDTH,
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int SHIFT      = CNN_SHIFT,
  parameter int RELU_EN    = 1
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] pix
);
  logic signed [ACC_WIDTH-1:0] shifted;

  always_comb begin
    shifted = acc >>> SHIFT;
    if (RELU_EN != 0 && shifted[ACC_WIDTH-1]) shifted = '0;
    pix = DATA_WIDTH'(sat_clip(longint'(shifted), DATA_WIDTH));
  end
endmodule

// File: rtl/conv3x3_window.sv
// Streaming 3x3 convolution: column window, 9-tap kernel, product regs, adder tree.
module conv3x3_window
  import conv3x3_window_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int IMG_WIDTH  = CNN_IMG_WIDTH,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + 4,
  parameter int SHIFT      = CNN_SHIFT,
  parameter int RELU_EN    = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  conv3x3_window_if.slave bus
);
  localparam int STAGES = 2;
  localparam int PW     = 2*DATA_WIDTH;

  logic [2:0][2:0][DATA_WIDTH-1:0]     win;   // [row][col], col 0 is the oldest
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] kern;
  logic [NUM_TAPS-1:0][PW-1:0]         prod_d, prod_q;
  logic [STAGES:0]                     vld_pipe;
  col_t [STAGES:0]                     col_pipe;
  col_t                                col_cnt;
  logic signed [ACC_WIDTH-1:0]         sum;
  logic signed [DATA_WIDTH-1:0]        pix_d, pix_q;
  logic                                beat_ok;

  // Beats at col 0/1 would mix the previous row into the window.
  assign beat_ok = bus.in_valid && (col_cnt >= col_t'(2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win     <= '0;
      col_cnt <= '0;
    end else if (bus.in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= bus.row0_px;
      win[1][2] <= bus.row1_px;
      win[2][2] <= bus.row2_px;
      col_cnt   <= (col_cnt == col_t'(IMG_WIDTH-1)) ? '0 : col_cnt + col_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      kern <= '0;
    else if (bus.w_we && bus.w_addr <= 4'd8)
      kern[bus.w_addr] <= bus.w_data;
  end

  always_comb begin
    prod_d = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        prod_d[r*3+c] = PW'($signed(kern[r*3+c])) * PW'($signed(win[r][c]));
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_TAPS; k++)
      sum = sum + ACC_WIDTH'($signed(prod_q[k]));
  end

  sat_shift #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .SHIFT     (SHIFT),
    .RELU_EN   (RELU_EN)
  ) u_sat (
    .acc(sum),
    .pix(pix_d)
  );

  // Valid bits advance every cycle; data regs load only behind a valid bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      col_pipe <= '0;
      prod_q   <= '0;
      pix_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], beat_ok};
      if (beat_ok) col_pipe[0] <= col_cnt - col_t'(1);
      for (int s = 1; s <= STAGES; s++)
        if (vld_pipe[s-1]) col_pipe[s] <= col_pipe[s-1];
      if (vld_pipe[0]) prod_q <= prod_d;
      if (vld_pipe[1]) pix_q  <= pix_d;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.pix_out   = pix_q;
  assign bus.out_col   = col_pipe[STAGES];
endmodule

// File: tb/tb_conv3x3_window.sv
// Bench for conv3x3_window: two parameterisations share one stimulus stream and an image-level model.
module tb_conv3x3_window;
  import conv3x3_window_pkg::*;

  localparam int DW = 8;
  localparam int W  = 28;

  typedef struct {
    int due;
    int pix;
    int col;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  conv3x3_window_if #(.DATA_WIDTH(DW)) bus_a ();
  conv3x3_window_if #(.DATA_WIDTH(DW)) bus_b ();

  assign bus_b.in_valid = bus_a.in_valid;
  assign bus_b.row0_px  = bus_a.row0_px;
  assign bus_b.row1_px  = bus_a.row1_px;
  assign bus_b.row2_px  = bus_a.row2_px;
  assign bus_b.w_we     = bus_a.w_we;
  assign bus_b.w_addr   = bus_a.w_addr;
  assign bus_b.w_data   = bus_a.w_data;

  // A: SHIFT 4 with ReLU; B: SHIFT 0 without ReLU.
  conv3x3_window #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .ACC_WIDTH(20), .SHIFT(4), .RELU_EN(1))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  conv3x3_window #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .ACC_WIDTH(20), .SHIFT(0), .RELU_EN(0))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int cnt_a = 0;

  int   img [3][W];
  int   mk  [9];
  int   mcol = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   la_pix = 0, la_col = 0, lb_pix = 0, lb_col = 0;

  task automatic check(input string nm, input logic signed [63:0] got, input logic signed [63:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  function automatic int exp_px(input int s, input int sh, input bit relu);
    int v;
    v = s >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  // Model: keep the current image row by column and convolve the 3 columns ending at each beat.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcol = 0;
      foreach (mk[i]) mk[i] = 0;
      qa.delete();
      qb.delete();
    end else begin
      cyc++;
      if (bus_a.w_we && bus_a.w_addr <= 4'd8) mk[bus_a.w_addr] = int'($signed(bus_a.w_data));
      if (bus_a.in_valid) begin
        img[0][mcol] = int'($signed(bus_a.row0_px));
        img[1][mcol] = int'($signed(bus_a.row1_px));
        img[2][mcol] = int'($signed(bus_a.row2_px));
        if (mcol >= 2) begin
          int s;
          s = 0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              s += mk[r*3+c] * img[r][mcol-2+c];
          qa.push_back('{cyc + 2, exp_px(s, 4, 1'b1), mcol - 1});
          qb.push_back('{cyc + 2, exp_px(s, 0, 1'b0), mcol - 1});
        end
        mcol = (mcol == W - 1) ? 0 : mcol + 1;
      end
    end
  end

  // Every cycle: out_valid against the model, pix_out/out_col against the newest or held value.
  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    if (!reset_n) begin
      la_pix = 0; la_col = 0; lb_pix = 0; lb_col = 0;
    end
    ev = (qa.size() > 0 && qa[0].due == cyc);
    if (ev) begin e = qa.pop_front(); la_pix = e.pix; la_col = e.col; end
    check("a.out_valid", bus_a.out_valid, ev);
    check("a.pix_out", $signed(bus_a.pix_out), la_pix);
    check("a.out_col", bus_a.out_col, la_col);
    ev = (qb.size() > 0 && qb[0].due == cyc);
    if (ev) begin e = qb.pop_front(); lb_pix = e.pix; lb_col = e.col; end
    check("b.out_valid", bus_b.out_valid, ev);
    check("b.pix_out", $signed(bus_b.pix_out), lb_pix);
    check("b.out_col", bus_b.out_col, lb_col);
    if (bus_a.out_valid) cnt_a++;
  end

  task automatic beat(input int r0, input int r1, input int r2);
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    bus_a.w_we     = 1'b0;
    bus_a.row0_px  = DW'(r0);
    bus_a.row1_px  = DW'(r1);
    bus_a.row2_px  = DW'(r2);
  endtask

  task automatic gap();
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.w_we     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) gap();
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.w_we     = 1'b1;
    bus_a.w_addr   = 4'(a);
    bus_a.w_data   = DW'(d);
  endtask

  task automatic fill_kernel(input int centre, input int others);
    for (int i = 0; i < 9; i++) wr(i, (i == 4) ? centre : others);
  endtask

  initial begin
    int c0;
    bus_a.in_valid = 1'b0;
    bus_a.row0_px  = '0;
    bus_a.row1_px  = '0;
    bus_a.row2_px  = '0;
    bus_a.w_we     = 1'b0;
    bus_a.w_addr   = '0;
    bus_a.w_data   = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset a.out_valid", bus_a.out_valid, 0);
    check("reset a.pix_out", $signed(bus_a.pix_out), 0);
    check("reset a.out_col", bus_a.out_col, 0);
    check("reset b.out_valid", bus_b.out_valid, 0);
    #2 reset_n = 1'b1;

    // Identity kernel, centre row carries the column index.
    fill_kernel(16, 0);
    c0 = cnt_a;
    for (int c = 0; c < W; c++) beat(50, c, -50);
    idle(4);
    check("identity count", cnt_a - c0, 26);
    check("identity last a.pix", $signed(bus_a.pix_out), 26);
    check("identity last a.col", bus_a.out_col, 26);
    check("identity last b.pix", $signed(bus_b.pix_out), 127);

    // Out-of-range tap write, then the same row with alternating gaps.
    wr(12, 99);
    c0 = cnt_a;
    for (int c = 0; c < W; c++) begin beat(50, c, -50); gap(); end
    idle(4);
    check("gapped count", cnt_a - c0, 26);
    check("gapped last a.pix", $signed(bus_a.pix_out), 26);

    // Box sum: saturates high, and low on the non-ReLU instance.
    fill_kernel(16, 16);
    for (int c = 0; c < W; c++) beat(20, 20, 20);
    idle(4);
    check("box +20 a.pix", $signed(bus_a.pix_out), 127);
    check("box +20 b.pix", $signed(bus_b.pix_out), 127);
    for (int c = 0; c < W; c++) beat(-20, -20, -20);
    idle(4);
    check("box -20 a.pix", $signed(bus_a.pix_out), 0);
    check("box -20 b.pix", $signed(bus_b.pix_out), -128);

    // ReLU with negative kernel.
    fill_kernel(-1, -1);
    for (int c = 0; c < W; c++) beat(5, 5, 5);
    idle(4);
    check("relu a.pix", $signed(bus_a.pix_out), 0);
    check("relu b.pix", $signed(bus_b.pix_out), -45);

    // Three back-to-back rows, random kernel and pixels.
    for (int i = 0; i < 9; i++) wr(i, int'($urandom_range(0, 15)) - 8);
    c0 = cnt_a;
    for (int c = 0; c < 3*W; c++)
      beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128);
    idle(4);
    check("row wrap count", cnt_a - c0, 78);
    check("row wrap last a.col", bus_a.out_col, 26);

    // Reset between clock edges while col 15 is streaming.
    fill_kernel(16, 0);
    for (int c = 0; c <= 15; c++) beat(50, c, -50);
    @(posedge clk);
    #2;
    check("pre-reset a.out_valid", bus_a.out_valid, 1);
    check("pre-reset a.pix", $signed(bus_a.pix_out), 12);
    bus_a.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async reset a.out_valid", bus_a.out_valid, 0);
    check("async reset b.out_valid", bus_b.out_valid, 0);
    check("async reset a.pix", $signed(bus_a.pix_out), 0);
    check("async reset a.col", bus_a.out_col, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    c0 = cnt_a;
    for (int c = 0; c < W; c++) beat(9, 9, 9);
    idle(4);
    check("post-reset count", cnt_a - c0, 26);
    check("post-reset a.pix", $signed(bus_a.pix_out), 0);
    check("post-reset b.pix", $signed(bus_b.pix_out), 0);
    check("post-reset a.col", bus_a.out_col, 26);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/conv3x3_window.md
# conv3x3_window

Streaming 3×3 convolution stage placed directly downstream of the three-row line buffer. Each valid beat, it takes one column of three vertically aligned pixels (rows 0, 1 and 2) and shifts it into a 3×3 window. Once the window holds three columns of the current image row, it multiplies the window by a locally stored 9-tap signed kernel, sums the products, scales and saturates the result, and emits one output pixel. It produces IMG_WIDTH-2 outputs per image row, with no padding.

## Interface
- DATA_WIDTH, 8: signed pixel and weight width.
- IMG_WIDTH, 28: columns per image row.
- ACC_WIDTH, 2*DATA_WIDTH+4: accumulator width; a full sum of 9 products cannot overflow it.
- SHIFT, 4: arithmetic right shift applied to the sum before saturation.
- RELU_EN, 1: when 1, negative results are clamped to 0.

- clk, in, 1: single clock; everything is sampled on its rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: a column beat is present on the three pixel inputs.
- row0_px / row1_px / row2_px, in, DATA_WIDTH signed: pixels at the current column; row0 is the top row.
- w_we, in, 1: kernel write strobe.
- w_addr, in, 4: kernel tap index, row-major, 0..8.
- w_data, in, DATA_WIDTH signed: kernel tap value.
- out_valid, out, 1: pix_out is valid this cycle.
- pix_out, out, DATA_WIDTH signed: convolution result.
- out_col, out, 16: column index of the window centre, 1..IMG_WIDTH-2.

## Operation
- **Reset.** reset_n low clears the following immediately, without waiting for a clock edge, and they stay cleared while it is low:
  - window, column counter, pipeline valid bits, out_valid, pix_out, out_col all go to 0;
  - all 9 kernel taps go to 0.
- **Column counter (col_cnt, 0..IMG_WIDTH-1).**
  - Increments on each in_valid beat.
  - Wraps to 0 after IMG_WIDTH-1.
  - Holds when in_valid is low.
- **Window shift.** On each in_valid beat, column 2 moves to column 1, column 1 moves to column 0, and the new (row0_px, row1_px, row2_px) loads into column 2.
- **Window-valid rule.**
  - A beat produces an output iff its col_cnt value is ≥ 2 at the time of the beat.
  - This blocks windows that straddle the row wrap, so beats at col 0 and col 1 of every row produce nothing.
  - The centre column reported is col_cnt-1.
- **Arithmetic.**
  - Each product is w[k]·px[k], signed, 2*DATA_WIDTH bits wide.
  - The sum is sign-extended to ACC_WIDTH.
  - The sum is then arithmetic-shifted right by SHIFT.
  - If RELU_EN is 1, a negative shifted value becomes 0.
  - The result saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **Kernel writes.**
  - w_we with w_addr ≤ 8 writes the tap at the clock edge.
  - w_addr 9..15 is ignored.
  - A write becomes visible to the multiply stage on the next edge.
  - Writing during streaming is legal, but any window already in the multiply stage uses the old value. Software loads the kernel before the stream starts.
- **No backpressure.** The block accepts every in_valid beat and never stalls.
- **Gaps in in_valid.** Stage valid bits propagate through the pipeline every cycle regardless of in_valid, so outputs already in flight still emerge during an input gap.

## Timing
- **Pipeline stages.**
  - S0: window register, updated at edge e, which samples the beat.
  - S1: 9 product registers, edge e+1.
  - S2: adder tree, shift, ReLU and saturate into pix_out/out_valid/out_col, edge e+2.
- **Latency.** A beat sampled at edge e produces out_valid high from edge e+2 for exactly one cycle.
- **Throughput.** One output per cycle when in_valid is continuously high.
- **Outputs when idle.**
  - out_valid is low on any cycle with no qualifying beat.
  - pix_out and out_col hold their last value when out_valid is low.
- **Reset mid-stream.**
  - Everything in flight is discarded, and out_valid drops immediately (asynchronous).
  - After reset_n rises, col_cnt restarts at 0, so the next beat is treated as column 0.
  - The kernel must be reloaded after reset.
- **Simultaneous events.** A kernel write and an input beat in the same cycle are both accepted.

## Structure
- **Shared package / cnn_params header:**
  - DATA_WIDTH, IMG_WIDTH, ACC_WIDTH, SHIFT defaults;
  - the saturate-to-DATA_WIDTH function, which other stages reuse.
- **One sub-module, `sat_shift`:** combinational shift + ReLU + saturate, parameterised by ACC_WIDTH, DATA_WIDTH, SHIFT and RELU_EN.
- **Top level contains:** the window and column counter, the kernel register file, the product registers and the adder tree.

## Test plan
- **Identity kernel.** Centre tap = 16, all others 0, SHIFT=4. Stream one row with row1_px = col. Expect out_valid on cols 2..27, pix_out = centre value (1..26) and out_col 1..26, each 2 edges after its beat.
- **Box sum with saturation.** All 9 taps = 1, SHIFT=0, every pixel = 20. Expect pix_out = 127. Repeat with every pixel = -20 and RELU_EN=0: expect -128.
- **ReLU.** RELU_EN=1, all taps = -1, pixels = 5. Expect pix_out = 0 for every output.
- **Row wrap.** Stream 3 consecutive rows, IMG_WIDTH=28. Expect exactly 26 outputs per row, with no output on beats at col 0 or col 1.
- **Gapped input and write-address guard.**
  - Toggle in_valid 1-0-1-0. Expect outputs to match the continuous run, value for value.
  - Issue a write with w_addr=12. Expect the kernel to be unchanged.
- **Async reset mid-stream.** Assert reset_n low between clock edges at col 15. Expect out_valid = 0 immediately and all kernel taps = 0. Expect the next row's outputs to start at its third beat.
